// File: rtl/seq_alu.sv
// Multi-cycle integer ALU: single-cycle base ops plus iterative RV32M-style multiply/divide,
// with valid/ready handshakes on both the request and the result side.
module seq_alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] ALUop1_i,
    input  logic [WIDTH-1:0] ALUop2_i,
    input  logic [3:0]       ALUctrl_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] ALUout_o,
    output logic             zero_o
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned CW  = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;

    logic [WIDTH-1:0] a, b;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] min_val;
    logic             accept;
    logic             is_single, is_mul, is_div, div_signed, div_quot;
    logic             div_zero, div_ovf;
    logic [WIDTH-1:0] div_edge;
    logic [WIDTH-1:0] mag_a, mag_b;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi, mul_lo;
    logic [WIDTH:0]   div_sh, div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] rem_n, quo_n, quo_fix, rem_fix;

    assign a       = ALUop1_i;
    assign b       = ALUop2_i;
    assign shamt   = ALUop2_i[SHW-1:0];
    assign min_val = {1'b1, {(WIDTH-1){1'b0}}};

    assign ready_o  = (state_q == StIdle) || ((state_q == StDone) && ready_i);
    assign valid_o  = (state_q == StDone);
    assign ALUout_o = res_q;
    assign zero_o   = zero_q;
    assign accept   = valid_i && ready_o;

    // Op decode: 0-9 base ops, 10-11 multiply, 12-15 divide (bit0 = unsigned, bit1 = remainder)
    assign is_single  = (ALUctrl_i < 4'd10);
    assign is_mul     = (ALUctrl_i[3:1] == 3'b101);
    assign is_div     = (ALUctrl_i[3:2] == 2'b11);
    assign div_signed = !ALUctrl_i[0];
    assign div_quot   = !ALUctrl_i[1];

    assign div_zero = (b == '0);
    assign div_ovf  = div_signed && (a == min_val) && (b == '1);

    always_comb begin
        div_edge = '0;
        if (div_zero) begin
            div_edge = div_quot ? '1 : a;
        end else if (div_ovf) begin
            div_edge = div_quot ? a : '0;
        end
    end

    assign mag_a = (div_signed && a[WIDTH-1]) ? (-a) : a;
    assign mag_b = (div_signed && b[WIDTH-1]) ? (-b) : b;

    always_comb begin
        alu_res = '0;
        unique case (ALUctrl_i)
            4'd0:    alu_res = a + b;
            4'd1:    alu_res = a - b;
            4'd2:    alu_res = a << shamt;
            4'd3:    alu_res = a | b;
            4'd4:    alu_res = a ^ b;
            4'd5:    alu_res = a >> shamt;
            4'd6:    alu_res = $signed(a) >>> shamt;
            4'd7:    alu_res = a & b;
            4'd8:    alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            4'd9:    alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            default: alu_res = '0;
        endcase
    end

    // Shift-add step: acc holds the running high half, lo shifts the multiplier out
    assign mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    assign mul_hi  = mul_sum[WIDTH:1];
    assign mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};

    // Restoring step: acc is the partial remainder, lo shifts dividend out and quotient in
    assign div_sh   = {acc_q, lo_q[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, opb_q};
    assign div_ge   = !div_diff[WIDTH];
    assign rem_n    = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
    assign quo_n    = {lo_q[WIDTH-2:0], div_ge};
    assign quo_fix  = negq_q ? (-quo_n) : quo_n;
    assign rem_fix  = negr_q ? (-rem_n) : rem_n;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        opb_d   = opb_q;
        res_d   = res_q;

        unique case (state_q)
            StIdle, StDone: begin
                if ((state_q == StDone) && ready_i) begin
                    state_d = StIdle;
                end
                if (accept) begin
                    op_d = ALUctrl_i[1:0];
                    if (is_single) begin
                        res_d   = alu_res;
                        state_d = StDone;
                    end else if (is_mul) begin
                        acc_d   = '0;
                        lo_d    = b;
                        opb_d   = a;
                        cnt_d   = CW'(WIDTH);
                        state_d = StMul;
                    end else if (is_div && (div_zero || div_ovf)) begin
                        res_d   = div_edge;
                        state_d = StDone;
                    end else begin
                        acc_d   = '0;
                        lo_d    = mag_a;
                        opb_d   = mag_b;
                        negq_d  = div_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                        negr_d  = div_signed && a[WIDTH-1];
                        cnt_d   = CW'(WIDTH);
                        state_d = StDiv;
                    end
                end
            end
            StMul: begin
                acc_d = mul_hi;
                lo_d  = mul_lo;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    res_d   = op_q[0] ? mul_hi : mul_lo;
                    state_d = StDone;
                end
            end
            StDiv: begin
                acc_d = rem_n;
                lo_d  = quo_n;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    res_d   = op_q[1] ? rem_fix : quo_fix;
                    state_d = StDone;
                end
            end
        endcase

        zero_d = (res_d == '0);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            acc_q   <= '0;
            lo_q    <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: a 32-bit and an 8-bit instance, directed vector table, hand sequences for
// backpressure and mid-operation reset, and random ops against an arithmetic reference model.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] op1, op2;
    logic [3:0]  ctrl;
    logic        rdy_in;
    logic        v32, v8;
    logic        r32, r8, vo32, vo8, z32, z8;
    logic [31:0] out32;
    logic [7:0]  out8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(32)) u32 (
        .clk_i(clk), .rst_n_i(rst_n), .valid_i(v32), .ready_o(r32),
        .ALUop1_i(op1), .ALUop2_i(op2), .ALUctrl_i(ctrl),
        .valid_o(vo32), .ready_i(rdy_in), .ALUout_o(out32), .zero_o(z32)
    );

    seq_alu #(.WIDTH(8)) u8 (
        .clk_i(clk), .rst_n_i(rst_n), .valid_i(v8), .ready_o(r8),
        .ALUop1_i(op1[7:0]), .ALUop2_i(op2[7:0]), .ALUctrl_i(ctrl),
        .valid_o(vo8), .ready_i(rdy_in), .ALUout_o(out8), .zero_o(z8)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV signed / and % already truncate toward zero
    function automatic logic [31:0] model(input int w, input logic [3:0] op,
                                          input logic [31:0] a_in, input logic [31:0] b_in);
        logic [63:0] m, a, b, r, p;
        longint      sa, sb;
        int          sh;
        m  = (64'd1 << w) - 64'd1;
        a  = {32'h0, a_in} & m;
        b  = {32'h0, b_in} & m;
        sa = a[w-1] ? longint'(a) - longint'(64'd1 << w) : longint'(a);
        sb = b[w-1] ? longint'(b) - longint'(64'd1 << w) : longint'(b);
        sh = int'(b % 64'(w));
        p  = a * b;
        r  = '0;
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a << sh;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = a >> sh;
            4'd6:  r = 64'(sa >>> sh);
            4'd7:  r = a & b;
            4'd8:  r = (sa < sb) ? 64'd1 : 64'd0;
            4'd9:  r = (a < b) ? 64'd1 : 64'd0;
            4'd10: r = p;
            4'd11: r = p >> w;
            4'd12: r = (b == 0) ? m : 64'(sa / sb);
            4'd13: r = (b == 0) ? m : a / b;
            4'd14: r = (b == 0) ? a : 64'(sa % sb);
            default: r = (b == 0) ? a : a % b;
        endcase
        return 32'(r & m);
    endfunction

    function automatic int exp_lat(input int w, input logic [3:0] op,
                                   input logic [31:0] a_in, input logic [31:0] b_in);
        logic [63:0] m, a, b;
        m = (64'd1 << w) - 64'd1;
        a = {32'h0, a_in} & m;
        b = {32'h0, b_in} & m;
        if (op < 4'd10) return 1;
        if (op < 4'd12) return w + 1;
        if (b == 0) return 1;
        if ((op == 4'd12 || op == 4'd14) && a == (64'd1 << (w - 1)) && b == m) return 1;
        return w + 1;
    endfunction

    // Issue one request with ready_i=1; lat counts cycles with the accept cycle as 1
    task automatic issue(input bit w8, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] res, output logic z,
                         output int lat, output bit rdy_low);
        int guard;
        @(negedge clk);
        op1 = a; op2 = b; ctrl = op; rdy_in = 1'b1;
        if (w8) v8 = 1'b1; else v32 = 1'b1;
        guard = 0;
        while (!(w8 ? r8 : r32) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        v8 = 1'b0; v32 = 1'b0;
        op1 = $urandom; op2 = $urandom; ctrl = 4'($urandom);
        lat = 1;
        rdy_low = 1'b1;
        while (!(w8 ? vo8 : vo32) && lat < 200) begin
            if (w8 ? r8 : r32) rdy_low = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        res = w8 ? {24'h0, out8} : out32;
        z   = w8 ? z8 : z32;
    endtask

    typedef struct {
        bit          w8;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    initial begin
        vec_t        vecs[$];
        logic [31:0] res;
        logic        z;
        int          lat;
        bit          rdy_low;
        int          guard;
        logic [31:0] sa[4], sb[4];

        rst_n = 1'b0; v32 = 1'b0; v8 = 1'b0; rdy_in = 1'b1;
        op1 = '0; op2 = '0; ctrl = '0;

        vecs.push_back('{0, 4'd0,  32'h7FFFFFFF, 32'h1,        32'h80000000, 1});
        vecs.push_back('{0, 4'd1,  32'd5,        32'd5,        32'h0,        1});
        vecs.push_back('{0, 4'd6,  32'h80000000, 32'd4,        32'hF8000000, 1});
        vecs.push_back('{0, 4'd9,  32'd1,        32'hFFFFFFFF, 32'd1,        1});
        vecs.push_back('{0, 4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        33});
        vecs.push_back('{0, 4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33});
        vecs.push_back('{0, 4'd12, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33});
        vecs.push_back('{0, 4'd14, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33});
        vecs.push_back('{0, 4'd13, 32'd100,      32'd7,        32'd14,       33});
        vecs.push_back('{0, 4'd15, 32'd100,      32'd7,        32'd2,        33});
        vecs.push_back('{0, 4'd13, 32'd1234,     32'd0,        32'hFFFFFFFF, 1});
        vecs.push_back('{0, 4'd14, 32'd9,        32'd0,        32'd9,        1});
        vecs.push_back('{0, 4'd12, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
        vecs.push_back('{0, 4'd14, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1});
        vecs.push_back('{1, 4'd12, 32'hF9,       32'h02,       32'hFD,       9});
        vecs.push_back('{1, 4'd14, 32'hF9,       32'h02,       32'hFF,       9});
        vecs.push_back('{1, 4'd13, 32'd100,      32'd7,        32'd14,       9});
        vecs.push_back('{1, 4'd15, 32'd100,      32'd7,        32'd2,        9});
        vecs.push_back('{1, 4'd13, 32'd5,        32'd0,        32'hFF,       1});
        vecs.push_back('{1, 4'd14, 32'd9,        32'd0,        32'd9,        1});
        vecs.push_back('{1, 4'd12, 32'h80,       32'hFF,       32'h80,       1});
        vecs.push_back('{1, 4'd14, 32'h80,       32'hFF,       32'h0,        1});

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid32", 64'(vo32), 64'd0);
        check("rst_out32", 64'(out32), 64'd0);
        check("rst_zero32", 64'(z32), 64'd0);
        check("rst_valid8", 64'(vo8), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rst_ready32", 64'(r32), 64'd1);
        check("rst_ready8", 64'(r8), 64'd1);

        foreach (vecs[i]) begin
            issue(vecs[i].w8, vecs[i].op, vecs[i].a, vecs[i].b, res, z, lat, rdy_low);
            check($sformatf("vec%0d_res", i), 64'(res), 64'(vecs[i].exp));
            check($sformatf("vec%0d_zero", i), 64'(z), 64'(vecs[i].exp == 0));
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
            if (vecs[i].lat > 1) check($sformatf("vec%0d_busy", i), 64'(rdy_low), 64'd1);
        end

        // Backpressure: mul result held for 5 cycles, then back-to-back adds
        @(negedge clk);
        op1 = 32'd3; op2 = 32'd5; ctrl = 4'd10; rdy_in = 1'b0; v32 = 1'b1;
        @(posedge clk);
        #1;
        v32 = 1'b0; op1 = $urandom; op2 = $urandom;
        guard = 0;
        while (!vo32 && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("bp_done", 64'(vo32), 64'd1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", 64'(vo32), 64'd1);
            check("bp_hold_out", 64'(out32), 64'd15);
            check("bp_hold_zero", 64'(z32), 64'd0);
        end
        for (int k = 0; k < 4; k++) begin
            sa[k] = $urandom;
            sb[k] = $urandom;
        end
        @(negedge clk);
        rdy_in = 1'b1; v32 = 1'b1; ctrl = 4'd0; op1 = sa[0]; op2 = sb[0];
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("b2b_valid", 64'(vo32), 64'd1);
            check($sformatf("b2b_out%0d", k), 64'(out32), 64'(sa[k] + sb[k]));
            if (k < 3) begin
                op1 = sa[k+1]; op2 = sb[k+1];
            end else begin
                v32 = 1'b0;
            end
        end

        // Reset in the middle of a divide
        issue(0, 4'd0, 32'd7, 32'd8, res, z, lat, rdy_low);
        check("pre_rst_add", 64'(res), 64'd15);
        @(negedge clk);
        op1 = 32'd1000; op2 = 32'd3; ctrl = 4'd13; rdy_in = 1'b1; v32 = 1'b1;
        @(posedge clk);
        #1;
        v32 = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("mid_div_busy", 64'(vo32), 64'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(vo32), 64'd0);
        check("mid_rst_out", 64'(out32), 64'd0);
        check("mid_rst_zero", 64'(z32), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", 64'(r32), 64'd1);
        issue(0, 4'd0, 32'd2, 32'd3, res, z, lat, rdy_low);
        check("post_rst_add", 64'(res), 64'd5);
        check("post_rst_lat", 64'(lat), 64'd1);

        // Random ops against the reference model
        for (int n = 0; n < 200; n++) begin
            bit          w8;
            logic [3:0]  op;
            logic [31:0] a, b;
            int          w;
            w8 = ($urandom_range(0, 3) == 0);
            w  = w8 ? 8 : 32;
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: begin a = w8 ? 32'h80 : 32'h80000000; b = 32'hFFFFFFFF; end
                2: a = 32'hFFFFFFFF;
                3: b = 32'($urandom_range(1, 9));
                default: ;
            endcase
            if (w8) begin
                a = a & 32'hFF;
                b = b & 32'hFF;
            end
            issue(w8, op, a, b, res, z, lat, rdy_low);
            check($sformatf("rnd%0d_w%0d_op%0d_%0h_%0h", n, w, op, a, b), 64'(res),
                  64'(model(w, op, a, b)));
            check($sformatf("rnd%0d_zero", n), 64'(z), 64'(model(w, op, a, b) == 0));
            check($sformatf("rnd%0d_lat", n), 64'(lat), 64'(exp_lat(w, op, a, b)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised multi-cycle successor to the single-cycle integer ALU in the execute stage.
- Adds RV32M-style iterative multiply/divide alongside the corrected base ops (add/sub/shift/logic/compare).
- Uses valid/ready handshakes on input and output so the pipeline can stall on long ops.
- Intended to replace the combinational ALU; single-cycle ops complete with 1-cycle latency.

Parameters:
WIDTH, 32, operand/result width in bits; power of two, 8..64
SHW, $clog2(WIDTH), derived; shift-amount bits taken from ALUop2_i[SHW-1:0]

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
valid_i  in  1  request valid
ready_o  out  1  block can accept a request this cycle
ALUop1_i  in  WIDTH  operand 1 (rs1)
ALUop2_i  in  WIDTH  operand 2 (rs2/imm)
ALUctrl_i  in  4  operation select
valid_o  out  1  result valid; held until consumed
ready_i  in  1  downstream accepts result
ALUout_o  out  WIDTH  result, registered
zero_o  out  1  ALUout_o == 0, registered with result

Behaviour:
- Op codes (ALUctrl_i): 0 add, 1 sub, 2 sll, 3 or, 4 xor, 5 srl, 6 sra, 7 and, 8 slt, 9 sltu, 10 mul (low WIDTH bits), 11 mulhu (high WIDTH bits, unsigned), 12 div, 13 divu, 14 rem, 15 remu.
- Arithmetic wraps modulo 2^WIDTH; slt/sltu produce 0 or 1 zero-extended; shifts use ALUop2_i[SHW-1:0] only; sra replicates the sign bit.
- Accept = valid_i && ready_o on a rising edge. Operands and op are captured at accept; later input changes have no effect.
- States:
  - IDLE: ready_o=1. Accept single-cycle op (0-9) -> DONE with result registered. Accept op 10-15 -> MUL or DIV; counter=WIDTH.
  - MUL: shift-add, one bit per cycle; counter decrements; at counter==1 -> DONE.
  - DIV: restoring divide on magnitudes, one bit per cycle; at counter==1 -> DONE with sign correction applied in the final update.
  - DONE: valid_o=1. If ready_i: return to IDLE, or accept a new request the same cycle (ready_o = ready_i in DONE).
- Latency accept -> valid_o: single-cycle ops 1 cycle; mul/div ops WIDTH+1 cycles; throughput 1 op/cycle for single-cycle ops when ready_i=1.
- ALUout_o and zero_o are stable while valid_o=1 && !ready_i (backpressure holds the result).
- Divide edge cases (RISC-V semantics), resolved at accept and completed in 1 cycle (straight to DONE):
  - divisor 0: div/divu -> all ones; rem/remu -> dividend.
  - signed overflow (op1 = -2^(WIDTH-1), op2 = -1): div -> op1; rem -> 0.
- Signs: quotient negative iff operand signs differ; remainder takes the dividend's sign.
- Reset (async, any state including mid-iteration): state=IDLE, valid_o=0, ALUout_o=0, zero_o=0, counter=0, in-flight op discarded; ready_o=1 once reset deasserts.
- Undefined ALUctrl_i values: none (all 16 are defined).

Test Plan:
- WIDTH=32: add 0x7FFFFFFF+1 -> 0x80000000 after 1 cycle; sub 5-5 -> 0 with zero_o=1; sra 0x80000000 by 4 -> 0xF8000000; sltu 1 vs 0xFFFFFFFF -> 1.
- mul 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001; mulhu -> 0xFFFFFFFE. valid_o asserts exactly 33 cycles after accept; ready_o=0 throughout.
- div -7/2 -> 0xFFFFFFFD, rem -> 0xFFFFFFFF; divu 100/7 -> 14, remu -> 2.
- divu x/0 -> 0xFFFFFFFF; rem 9/0 -> 9; div 0x80000000/-1 -> 0x80000000, rem -> 0. Each completes in 1 cycle.
- Backpressure: hold ready_i=0 for 5 cycles after a mul completes -> valid_o and ALUout_o stable; then back-to-back adds with ready_i=1 -> one result per cycle.
- Assert rst_n_i mid-divide (cycle 10) -> valid_o=0 and ALUout_o=0 immediately; after release a new add completes normally. Repeat the divide tests with WIDTH=8.
